hdmi_video_timing_ctrl: RTL and testbench
=========================================

// Module: hdmi_video_timing_ctrl
// PURPOSE
//  Sequences the three per-channel TMDS encoders. Generates raster timing (H/V counters,
//  sync pulses, data-enable) and pulls RGB pixels from an upstream stream source with a
//  valid/ready handshake. Outputs pixel data, data-valid and syncs registered and aligned,
//  ready to drive the encoders. Sits between the frame source and the encoders.
// PARAMETERS
//  H_ACTIVE   1280  active pixels per line
//  H_FP       110   horizontal front porch, px
//  H_SYNC     40    horizontal sync width, px
//  H_BP       220   horizontal back porch, px
//  V_ACTIVE   720   active lines per frame
//  V_FP       5     vertical front porch, lines
//  V_SYNC     5     vertical sync width, lines
//  V_BP       20    vertical back porch, lines
//  SYNC_POL   1     1: syncs active-high; 0: active-low
//  BLANK_RGB  24'h0 pixel substituted on underrun
// PORTS
//  clk_i              in   1   pixel clock
//  rst_i              in   1   synchronous reset, active-low
//  en_i               in   1   run enable; sampled only at frame boundary
//  px_data_i          in   24  upstream pixel {R,G,B}
//  px_data_valid_i    in   1   upstream pixel valid
//  px_sof_i           in   1   upstream start-of-frame, qualified by valid
//  px_data_ready_o    out  1   pixel accepted when valid & ready
//  px_data_o          out  24  pixel to encoders {R,G,B}
//  px_data_valid_o    out  1   data-enable to encoders
//  h_sync_o           out  1   horizontal sync to encoders
//  v_sync_o           out  1   vertical sync to encoders
//  underrun_o         out  1   sticky: active pixel needed but none valid
//  sof_err_o          out  1   sticky: SOF misaligned with raster
// BEHAVIOUR
//  - Reset (rst_i=0 at clk edge): counters 0, FSM IDLE, all outputs 0 except syncs at
//    inactive level (~SYNC_POL); sticky flags cleared. Reset mid-line aborts immediately.
//  - h_cnt 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; wraps to 0, then v_cnt
//    increments; v_cnt wraps at V_TOTAL-1. Counter widths $clog2(TOTAL).
//  - Line order: ACTIVE, FP, SYNC, BP; same order vertically. h_sync asserted for h_cnt
//    in SYNC region on every line; v_sync asserted for entire lines in V SYNC region.
//  - Frame FSM: IDLE -> ALIGN -> RUN. IDLE: counters held 0, outputs blank, syncs
//    inactive. On en_i=1 -> ALIGN. ALIGN: ready=1, discard beats until valid & sof
//    (that beat not consumed) -> RUN at h_cnt=v_cnt=0. RUN: free-running raster.
//    At last pixel of frame (h=H_TOTAL-1, v=V_TOTAL-1): en_i=0 -> IDLE, else stay.
//  - RUN: px_data_ready_o=1 only when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE (combinational
//    from counters). Beat consumed on valid & ready.
//  - Active cycle with valid=0: output BLANK_RGB, set underrun_o; raster never stalls.
//  - sof_i=1 on beat consumed at position other than (0,0): set sof_err_o, pixel still
//    used. sof_i=0 at (0,0): set sof_err_o. No resync until IDLE->ALIGN.
//  - Latency: 1 cycle. px_data_o/px_data_valid_o/h_sync_o/v_sync_o registered from
//    counter position and accepted beat of the previous cycle; all four mutually aligned.
//  - px_data_valid_o=1 iff previous-cycle position active; px_data_o=0 when not active.
//  - Sticky flags clear only on reset.
// STRUCTURE
//  - Package hdmi_pkg: typedef enum {IDLE, ALIGN, RUN} frame_state_t; typedef enum
//    {ACTIVE, FP, SYNC, BP} region_t; typedef struct packed {logic [7:0] r,g,b;} rgb_t.
//  - Sub-module video_axis_cnt: one porch/sync counter (TOTAL, region boundaries
//    params) emitting count, region, wrap; instantiated once for H, once for V
//    (V advanced by H wrap).
// TESTING (small raster: H 4/1/1/1, V 2/1/1/1; H_TOTAL=7, V_TOTAL=5)
//  - Reset: rst_i=0 3 cycles -> all outputs 0, syncs = ~SYNC_POL, flags 0.
//  - Startup: en_i=1, source sends 2 junk beats then sof -> junk discarded; first
//    px_data_valid_o one cycle after ALIGN->RUN, carrying sof pixel.
//  - Steady frame, source always valid with ramp 0..7 -> 4 valid px/line, 2 lines,
//    h_sync 1 cycle/line at h=5 (+1 latency), v_sync 7 cycles on line 3, flags 0.
//  - Underrun: drop valid for pixel (2,1) -> that output = BLANK_RGB,
//    px_data_valid_o still 1, underrun_o=1 and stays 1.
//  - SOF error: sof_i=1 on pixel (1,0) -> sof_err_o=1, raster unchanged.
//  - Stop: en_i=0 mid-frame -> frame completes, IDLE at next (0,0), ready=0, blank.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types for the HDMI video timing controller: frame FSM states,
// raster regions and the packed RGB pixel.
package hdmi_pkg;

    typedef enum logic [1:0] {IDLE, ALIGN, RUN} frame_state_t;

    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Sync pins idle at ~pol and go to pol while the sync region is asserted.
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// One raster axis counter (used for both H and V): counts 0..TOTAL-1 and
// decodes which of ACTIVE/FP/SYNC/BP the current count falls into.
module video_axis_cnt
    import hdmi_pkg::*;
#(
    parameter int ACTIVE_LEN = 1280,
    parameter int FP_LEN     = 110,
    parameter int SYNC_LEN   = 40,
    parameter int BP_LEN     = 220,
    localparam int TOTAL     = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN,
    localparam int W         = $clog2(TOTAL)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         adv_i,
    output logic [W-1:0] cnt_o,
    output region_t      region_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] FP_START   = W'(ACTIVE_LEN);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE_LEN + FP_LEN);
    localparam logic [W-1:0] BP_START   = W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = adv_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        if (cnt_q < FP_START) begin
            region_o = ACTIVE;
        end else if (cnt_q < SYNC_START) begin
            region_o = FP;
        end else if (cnt_q < BP_START) begin
            region_o = SYNC;
        end else begin
            region_o = BP;
        end
    end

endmodule

// File: rtl/hdmi_video_timing_ctrl.sv
// Raster timing generator feeding the three TMDS encoders: pulls pixels from a
// valid/ready source and emits pixel, data-enable and syncs with one cycle latency.
module hdmi_video_timing_ctrl
    import hdmi_pkg::*;
#(
    parameter int          H_ACTIVE  = 1280,
    parameter int          H_FP      = 110,
    parameter int          H_SYNC    = 40,
    parameter int          H_BP      = 220,
    parameter int          V_ACTIVE  = 720,
    parameter int          V_FP      = 5,
    parameter int          V_SYNC    = 5,
    parameter int          V_BP      = 20,
    parameter logic        SYNC_POL  = 1'b1,
    parameter logic [23:0] BLANK_RGB = 24'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [23:0] px_data_i,
    input  logic        px_data_valid_i,
    input  logic        px_sof_i,
    output logic        px_data_ready_o,
    output logic [23:0] px_data_o,
    output logic        px_data_valid_o,
    output logic        h_sync_o,
    output logic        v_sync_o,
    output logic        underrun_o,
    output logic        sof_err_o
);

    localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    frame_state_t   state_q, state_d;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    region_t        h_region, v_region;
    logic           h_wrap, v_wrap;
    logic           run, active, accept, at_origin, ready;

    rgb_t pix_q, pix_d;
    logic dv_q, dv_d, hs_q, hs_d, vs_q, vs_d;
    logic underrun_q, underrun_d, sof_err_q, sof_err_d;

    assign run       = (state_q == RUN);
    assign active    = run && (h_region == ACTIVE) && (v_region == ACTIVE);
    assign accept    = active && px_data_valid_i;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // Counters sit at zero outside RUN so the first RUN cycle is always (0,0).
    video_axis_cnt #(
        .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)
    ) u_h_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!run),
        .adv_i   (run),
        .cnt_o   (h_cnt),
        .region_o(h_region),
        .wrap_o  (h_wrap)
    );

    video_axis_cnt #(
        .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)
    ) u_v_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!run),
        .adv_i   (h_wrap),
        .cnt_o   (v_cnt),
        .region_o(v_region),
        .wrap_o  (v_wrap)
    );

    // The SOF beat is held back in ALIGN so it is consumed as pixel (0,0) in RUN.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) state_d = ALIGN;
            end
            ALIGN: begin
                ready = !(px_data_valid_i && px_sof_i);
                if (px_data_valid_i && px_sof_i) state_d = RUN;
            end
            RUN: begin
                ready = active;
                if (v_wrap && !en_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_d      = '0;
        dv_d       = active;
        hs_d       = sync_level(run && (h_region == SYNC), SYNC_POL);
        vs_d       = sync_level(run && (v_region == SYNC), SYNC_POL);
        underrun_d = underrun_q | (active && !px_data_valid_i);
        sof_err_d  = sof_err_q | (accept && (px_sof_i != at_origin));
        if (active) begin
            pix_d = accept ? rgb_t'(px_data_i) : rgb_t'(BLANK_RGB);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            dv_q       <= 1'b0;
            hs_q       <= ~SYNC_POL;
            vs_q       <= ~SYNC_POL;
            underrun_q <= 1'b0;
            sof_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            dv_q       <= dv_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            underrun_q <= underrun_d;
            sof_err_q  <= sof_err_d;
        end
    end

    assign px_data_ready_o = ready;
    assign px_data_o       = pix_q;
    assign px_data_valid_o = dv_q;
    assign h_sync_o        = hs_q;
    assign v_sync_o        = vs_q;
    assign underrun_o      = underrun_q;
    assign sof_err_o       = sof_err_q;

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Directed bench for hdmi_video_timing_ctrl on a 7x5 raster (H 4/1/1/1, V 2/1/1/1):
// reset, alignment, steady frame, underrun, SOF error and stop at frame end.
module tb_hdmi_video_timing_ctrl;

    localparam logic [23:0] BLANK = 24'hABCDEF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [23:0] px_data_i = '0;
    logic        px_data_valid_i = 1'b0;
    logic        px_sof_i = 1'b0;
    logic        px_data_ready_o;
    logic [23:0] px_data_o;
    logic        px_data_valid_o;
    logic        h_sync_o;
    logic        v_sync_o;
    logic        underrun_o;
    logic        sof_err_o;

    int testsRun = 0;
    int testsFailed = 0;
    int nextIdx = 0;
    logic expUnder = 1'b0;
    logic expSofErr = 1'b0;

    hdmi_video_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .BLANK_RGB(BLANK)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .px_data_i      (px_data_i),
        .px_data_valid_i(px_data_valid_i),
        .px_sof_i       (px_sof_i),
        .px_data_ready_o(px_data_ready_o),
        .px_data_o      (px_data_o),
        .px_data_valid_o(px_data_valid_o),
        .h_sync_o       (h_sync_o),
        .v_sync_o       (v_sync_o),
        .underrun_o     (underrun_o),
        .sof_err_o      (sof_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] ramp(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'h10 | b, 8'h20 | b, 8'h30 | b};
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkPixel(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic sof, input logic [23:0] data);
        px_data_valid_i = valid;
        px_sof_i        = sof;
        px_data_i       = data;
    endtask

    task automatic checkBlank(input string tag);
        checkOutput({tag, " dv"}, px_data_valid_o, 1'b0);
        checkPixel({tag, " data"}, px_data_o, 24'h0);
        checkOutput({tag, " hsync"}, h_sync_o, 1'b0);
        checkOutput({tag, " vsync"}, v_sync_o, 1'b0);
    endtask

    // Runs one whole frame starting at (0,0), entered at posedge+1.
    task automatic runFrame(input int dropH, input int dropV, input int sofH, input int sofV,
                            input logic stopMid);
        for (int v = 0; v < 5; v++) begin
            for (int h = 0; h < 7; h++) begin
                logic act, drop, badSof;
                logic [23:0] expData;
                act    = (h < 4) && (v < 2);
                drop   = (h == dropH) && (v == dropV);
                badSof = (h == sofH) && (v == sofV);
                if (stopMid && v == 2 && h == 0) en_i = 1'b0;
                applyStimulus(!drop, (nextIdx == 0) || badSof, ramp(nextIdx));
                #1;
                checkOutput($sformatf("ready(%0d,%0d)", h, v), px_data_ready_o, act);
                expData = act ? (drop ? BLANK : ramp(nextIdx)) : 24'h0;
                if (act && drop) expUnder = 1'b1;
                if (act && !drop && badSof) expSofErr = 1'b1;
                if (act) nextIdx = (nextIdx + 1) % 8;
                @(posedge clk_i);
                #1;
                checkOutput($sformatf("dv(%0d,%0d)", h, v), px_data_valid_o, act);
                checkPixel($sformatf("data(%0d,%0d)", h, v), px_data_o, expData);
                checkOutput($sformatf("hsync(%0d,%0d)", h, v), h_sync_o, h == 5);
                checkOutput($sformatf("vsync(%0d,%0d)", h, v), v_sync_o, v == 3);
                checkOutput($sformatf("underrun(%0d,%0d)", h, v), underrun_o, expUnder);
                checkOutput($sformatf("soferr(%0d,%0d)", h, v), sof_err_o, expSofErr);
            end
        end
    endtask

    initial begin
        // Reset held for three cycles.
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkBlank("reset");
        checkOutput("reset ready", px_data_ready_o, 1'b0);
        checkOutput("reset underrun", underrun_o, 1'b0);
        checkOutput("reset soferr", sof_err_o, 1'b0);

        // Idle with enable low: nothing requested, outputs blank.
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b1, ramp(0));
        @(posedge clk_i);
        #1;
        checkOutput("idle ready", px_data_ready_o, 1'b0);
        checkBlank("idle");

        // Enable: IDLE -> ALIGN, then two junk beats discarded.
        en_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 24'h0);
        @(posedge clk_i);
        #1;
        checkOutput("align ready", px_data_ready_o, 1'b1);
        for (int j = 0; j < 2; j++) begin
            applyStimulus(1'b1, 1'b0, 24'h5A5A00 + 24'(j));
            #1;
            checkOutput($sformatf("junk%0d ready", j), px_data_ready_o, 1'b1);
            @(posedge clk_i);
            #1;
            checkBlank($sformatf("junk%0d", j));
        end

        // SOF beat: ALIGN -> RUN, pixel not yet consumed.
        nextIdx = 0;
        applyStimulus(1'b1, 1'b1, ramp(0));
        @(posedge clk_i);
        #1;
        checkBlank("sof enter");

        // Steady frame, then underrun frame, then SOF-error frame with stop.
        runFrame(-1, -1, -1, -1, 1'b0);
        runFrame(2, 1, -1, -1, 1'b0);
        runFrame(-1, -1, 1, 0, 1'b1);

        // Frame completed and controller returned to IDLE.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, ramp(0));
            #1;
            checkOutput($sformatf("stop%0d ready", k), px_data_ready_o, 1'b0);
            @(posedge clk_i);
            #1;
            checkBlank($sformatf("stop%0d", k));
            checkOutput($sformatf("stop%0d underrun", k), underrun_o, 1'b1);
            checkOutput($sformatf("stop%0d soferr", k), sof_err_o, 1'b1);
        end

        // Sticky flags clear only on reset.
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("rst2 underrun", underrun_o, 1'b0);
        checkOutput("rst2 soferr", sof_err_o, 1'b0);
        checkBlank("rst2");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
